alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter N, default 32, meaning datapath width; legal values are powers of two, 8 to 64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: an operation is presented.
REQ-005 SHALL have port in_ready, output, 1 bit: an operation can be accepted.
REQ-006 SHALL have ports operand1 and operand2, inputs, N bits each: the source operands.
REQ-007 SHALL have port alucontrol, input, 4 bits: base op code, using the ALU_* encodings from defines.svh (ADD, SUB, AND, OR, XOR, EQ, SLT, SLTU, SLL, SRL, SRA).
REQ-008 SHALL have port md_en, input, 1 bit: when 1, md_op selects the operation and alucontrol is ignored.
REQ-009 SHALL have port md_op, input, 3 bits, with RV32M funct3 meaning: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-010 SHALL have port out_valid, output, 1 bit: alu_result and zero are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port alu_result, output, N bits: the registered result.
REQ-013 SHALL have port zero, output, 1 bit: registered flag equal to (alu_result == 0).
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV, DONE; in_ready is 1 only in IDLE.
REQ-016 SHALL accept an operation on the cycle T where in_valid && in_ready, latching operands and op code; in_valid outside IDLE is ignored.
REQ-017 SHALL complete base ops and MUL/DIV special cases by going IDLE->DONE, with out_valid high at T+1.
REQ-018 SHALL compute MUL* with an iterative shift-add over N cycles (IDLE->MUL->DONE), with out_valid high at T+N+1.
REQ-019 SHALL form the 2N-bit product from operand magnitudes, then negate it when the signs differ: MULH treats both operands as signed, MULHSU treats operand1 as signed and operand2 as unsigned, MULHU treats both as unsigned.
REQ-020 SHALL return the low N bits of the product for MUL and the high N bits for MULH, MULHSU and MULHU.
REQ-021 SHALL compute DIV* with an iterative restoring divider over N cycles (IDLE->DIV->DONE), with out_valid high at T+N+1.
REQ-022 SHALL give the signed quotient the XOR of the operand signs and the signed remainder the sign of the dividend, truncating toward zero.
REQ-023 SHALL, on division by zero, return quotient all-ones and remainder = operand1, both at T+1.
REQ-024 SHALL, on signed overflow (operand1 = most-negative, operand2 = all-ones), return quotient = operand1 and remainder 0, both at T+1.
REQ-025 SHALL use only operand2[log2(N)-1:0] as the shift amount for SLL, SRL and SRA; SRA fills with operand1[N-1].
REQ-026 SHALL compute SLT as a true signed comparison and EQ/SLT/SLTU as a 0/1 value zero-extended to N bits.
REQ-027 SHALL produce alu_result 0 for an unknown base alucontrol code.
REQ-028 SHALL in DONE hold out_valid, alu_result and zero stable until out_ready is 1, then return to IDLE on the next cycle, with out_valid low.
REQ-029 SHALL accept a new op no earlier than the cycle after the handshake (no back-to-back overlap).

Reset
REQ-030 SHALL, while rst is 1 at a clock edge, enter IDLE with out_valid=0, alu_result=0, zero=1, busy=0 and in_ready=1 from the next cycle.
REQ-031 SHALL treat rst as having priority over all other inputs, including during MUL, DIV or DONE; any partial or unconsumed result is discarded.

Verification
REQ-032 SHALL be verified by: N=32, ADD 5+7 accepted at T -> out_valid at T+1, alu_result=12, zero=0.
REQ-033 SHALL be verified by: MULH 0xFFFFFFFF,0xFFFFFFFF -> 0x00000000 at T+33; MULHU with the same operands -> 0xFFFFFFFE; MUL 0x10000,0x10000 -> 0, zero=1.
REQ-034 SHALL be verified by: DIV 0xFFFFFFF9 (-7), 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100,7 -> 14 at T+33.
REQ-035 SHALL be verified by: DIVU 100,0 -> 0xFFFFFFFF at T+1; REMU 100,0 -> 100; DIV 0x80000000,0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-036 SHALL be verified by: holding out_ready=0 for 5 cycles after out_valid -> result and zero held unchanged, in_ready=0, and a new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-037 SHALL be verified by: rst=1 at iteration 10 of a DIV -> next cycle busy=0, in_ready=1, out_valid=0; a subsequent SLL 1,33 -> 0x00000002.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: single-issue ALU with an iterative multiply/divide unit.
//
// Base ALU operations complete in one cycle. MUL/MULH/MULHSU/MULHU use a
// shift-add multiplier and DIV/DIVU/REM/REMU use a restoring divider. Each
// takes N iterations. Division by zero and signed overflow are resolved
// immediately. The result is held in DONE until the consumer takes it.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : operation presented          in_ready  : IDLE, can accept
//   operand1/2 : N-bit source operands
//   alucontrol : base op code (ALU_* below), ignored when md_en is 1
//   md_en      : select mul/div unit          md_op     : RV32M funct3
//   out_valid  : alu_result/zero valid        out_ready : consumer accepts
//   alu_result : registered result            zero      : alu_result == 0
//   busy       : not in IDLE

module alu_muldiv #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] operand1,
    input  logic [N-1:0] operand2,
    input  logic [3:0]   alucontrol,
    input  logic         md_en,
    input  logic [2:0]   md_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] alu_result,
    output logic         zero,
    output logic         busy
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;

    localparam int           SW       = $clog2(N);
    localparam logic [SW-1:0] LAST    = SW'(N - 1);
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;     // negate product / quotient
    logic            rneg_q, rneg_d;   // negate remainder
    logic [2*N-1:0]  acc_q, acc_d;     // mul: {hi, multiplier}; div: {rem, quo}
    logic [N-1:0]    opb_q, opb_d;     // multiplicand or divisor magnitude
    logic [N-1:0]    result_q, result_d;
    logic            zero_q, zero_d;

    function automatic logic [N-1:0] alu_base(input logic [3:0] ctl,
                                              input logic [N-1:0] a,
                                              input logic [N-1:0] b);
        logic signed [N-1:0] sa;
        logic [SW-1:0]       sh;
        sa = a;
        sh = b[SW-1:0];
        case (ctl)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLT:  return {{(N-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: return {{(N-1){1'b0}}, a < b};
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return N'(sa >>> sh);
            ALU_EQ:   return {{(N-1){1'b0}}, a == b};
            default:  return '0;
        endcase
    endfunction

    // Operand sign handling at issue: MULH/MULHSU/DIV/REM see operand1 as
    // signed, MULH/DIV/REM see operand2 as signed.
    logic         a_neg, b_neg;
    logic [N-1:0] a_mag, b_mag;

    always_comb begin
        a_neg = ((md_op == 3'd1) || (md_op == 3'd2) || (md_op == 3'd4) ||
                 (md_op == 3'd6)) && operand1[N-1];
        b_neg = ((md_op == 3'd1) || (md_op == 3'd4) || (md_op == 3'd6)) &&
                operand2[N-1];
        a_mag = a_neg ? -operand1 : operand1;
        b_mag = b_neg ? -operand2 : operand2;
    end

    // One shift-add step: add multiplicand to the high half when the
    // multiplier LSB is set, then shift the whole accumulator right.
    logic [N:0]     mul_sum;
    logic [2*N-1:0] mul_next, prod_fix;
    logic [N-1:0]   mul_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*N-1:N]} +
                   (acc_q[0] ? {1'b0, opb_q} : {(N+1){1'b0}});
        mul_next = {mul_sum, acc_q[N-1:1]};
        prod_fix = neg_q ? -mul_next : mul_next;
        mul_res  = (op_q == 3'd0) ? prod_fix[N-1:0] : prod_fix[2*N-1:N];
    end

    // One restoring step: shift the next dividend bit into the remainder,
    // keep the difference only when it did not borrow (bit N clear).
    logic [N:0]     div_shift, div_diff;
    logic           q_bit;
    logic [N-1:0]   rem_new, quo_fix, rem_fix, div_res;
    logic [2*N-1:0] div_next;

    always_comb begin
        div_shift = {acc_q[2*N-1:N], acc_q[N-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        q_bit     = ~div_diff[N];
        rem_new   = q_bit ? div_diff[N-1:0] : div_shift[N-1:0];
        div_next  = {rem_new, acc_q[N-2:0], q_bit};
        quo_fix   = neg_q ? -div_next[N-1:0] : div_next[N-1:0];
        rem_fix   = rneg_q ? -div_next[2*N-1:N] : div_next[2*N-1:N];
        div_res   = op_q[1] ? rem_fix : quo_fix;
    end

    always_comb begin
        // NOTE: every _d takes its hold value first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d   = md_op;
                    cnt_d  = '0;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    acc_d  = {{N{1'b0}}, a_mag};
                    opb_d  = b_mag;
                    if (!md_en) begin
                        result_d = alu_base(alucontrol, operand1, operand2);
                        state_d  = S_DONE;
                    end else if (!md_op[2]) begin
                        state_d = S_MUL;
                    end else if (operand2 == '0) begin
                        result_d = md_op[1] ? operand1 : '1;
                        state_d  = S_DONE;
                    end else if (!md_op[0] && operand1 == MOST_NEG &&
                                 operand2 == '1) begin
                        result_d = md_op[1] ? '0 : operand1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d = mul_res;
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d = div_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign alu_result = result_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench for alu_muldiv at N=32.
// Expected results and latencies are queued at issue and popped when the
// DUT raises out_valid.

module tb_alu_muldiv;

    localparam int N = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;

    localparam logic [2:0] MD_MUL = 3'd0, MD_MULH = 3'd1, MD_MULHSU = 3'd2,
                           MD_MULHU = 3'd3, MD_DIV = 3'd4, MD_DIVU = 3'd5,
                           MD_REM = 3'd6, MD_REMU = 3'd7;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  operand1, operand2;
    logic [3:0]    alucontrol;
    logic          md_en;
    logic [2:0]    md_op;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  alu_result;
    logic          zero;
    logic          busy;

    alu_muldiv #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operand1   (operand1),
        .operand2   (operand2),
        .alucontrol (alucontrol),
        .md_en      (md_en),
        .md_op      (md_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .zero       (zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent reference: 64-bit products and native SV division.
    function automatic logic [31:0] model(input bit md, input logic [2:0] op,
                                          input logic [3:0] ctl,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] pa, pb, p;
        if (!md) begin
            case (ctl)
                ALU_ADD:  return a + b;
                ALU_SUB:  return a - b;
                ALU_AND:  return a & b;
                ALU_OR:   return a | b;
                ALU_XOR:  return a ^ b;
                ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
                ALU_SLL:  return a << b[4:0];
                ALU_SRL:  return a >> b[4:0];
                ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
                ALU_EQ:   return (a == b) ? 32'd1 : 32'd0;
                default:  return 32'd0;
            endcase
        end
        pa = (op == MD_MULH || op == MD_MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
        pb = (op == MD_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = pa * pb;
        case (op)
            MD_MUL:  return p[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU: return p[63:32];
            MD_DIV:  begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'($signed(a) / $signed(b));
            end
            MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REM:  begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input bit md, input logic [2:0] op,
                                     input logic [31:0] a, input logic [31:0] b);
        if (!md) return 1;
        if (!op[2]) return N + 1;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return N + 1;
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic drive_op(input bit md, input logic [2:0] op,
                            input logic [3:0] ctl, input logic [31:0] a,
                            input logic [31:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check("in_ready_wait", {63'd0, in_ready}, 64'd1);
        in_valid   = 1'b1;
        md_en      = md;
        md_op      = op;
        alucontrol = ctl;
        operand1   = a;
        operand2   = b;
        @(posedge clk); #1;
        // Scramble inputs so a design that fails to latch them is exposed.
        in_valid   = 1'b0;
        md_en      = 1'($urandom);
        md_op      = 3'($urandom);
        alucontrol = 4'($urandom);
        operand1   = $urandom;
        operand2   = $urandom;
    endtask

    // Waits for out_valid, compares against the scoreboard head, optionally
    // stalls out_ready for hold cycles while offering an ignored op.
    task automatic collect(input int hold);
        exp_t e;
        int   lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        e = sb_q.pop_front();
        if (!out_valid) begin
            check({e.tag, ".timeout"}, 64'd0, 64'd1);
            return;
        end
        check({e.tag, ".lat"}, 64'(lat), 64'(e.lat));
        check({e.tag, ".res"}, {32'd0, alu_result}, {32'd0, e.res});
        check({e.tag, ".zero"}, {63'd0, zero}, {63'd0, e.res == 32'd0});
        for (int i = 0; i < hold; i++) begin
            in_valid   = 1'b1;
            md_en      = 1'b0;
            alucontrol = ALU_ADD;
            operand1   = 32'h1234;
            operand2   = 32'h1;
            @(posedge clk); #1;
            check({e.tag, ".hold_valid"}, {63'd0, out_valid}, 64'd1);
            check({e.tag, ".hold_res"}, {32'd0, alu_result}, {32'd0, e.res});
            check({e.tag, ".hold_zero"}, {63'd0, zero}, {63'd0, e.res == 32'd0});
            check({e.tag, ".hold_in_ready"}, {63'd0, in_ready}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({e.tag, ".post_valid"}, {63'd0, out_valid}, 64'd0);
        check({e.tag, ".post_in_ready"}, {63'd0, in_ready}, 64'd1);
        if (hold > 0) begin
            // The op offered during the stall must not have started.
            @(posedge clk); #1;
            check({e.tag, ".ignored_busy"}, {63'd0, busy}, 64'd0);
            check({e.tag, ".ignored_valid"}, {63'd0, out_valid}, 64'd0);
        end
    endtask

    task automatic run_op(input string tag, input bit md, input logic [2:0] op,
                          input logic [3:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat);
        exp_t e;
        drive_op(md, op, ctl, a, b);
        e.tag = tag;
        e.res = exp_res;
        e.lat = exp_lat;
        sb_q.push_back(e);
        collect(0);
    endtask

    initial begin
        exp_t e;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        md_en      = 1'b0;
        md_op      = '0;
        alucontrol = '0;
        operand1   = '0;
        operand2   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst.out_valid", {63'd0, out_valid}, 64'd0);
        check("rst.result", {32'd0, alu_result}, 64'd0);
        check("rst.zero", {63'd0, zero}, 64'd1);
        check("rst.busy", {63'd0, busy}, 64'd0);
        check("rst.in_ready", {63'd0, in_ready}, 64'd1);

        // Directed vectors, expected values derived by hand.
        run_op("add",        0, 3'd0,      ALU_ADD,  32'd5,          32'd7,          32'd12,         1);
        run_op("mulh_m1",    1, MD_MULH,   4'd0,     32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          33);
        run_op("mulhu_m1",   1, MD_MULHU,  4'd0,     32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33);
        run_op("mulhsu",     1, MD_MULHSU, 4'd0,     32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33);
        run_op("mul_wrap",   1, MD_MUL,    4'd0,     32'h0001_0000,  32'h0001_0000,  32'h0,          33);
        run_op("mul_small",  1, MD_MUL,    4'd0,     32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  33);
        run_op("div_neg",    1, MD_DIV,    4'd0,     32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
        run_op("rem_neg",    1, MD_REM,    4'd0,     32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
        run_op("divu",       1, MD_DIVU,   4'd0,     32'd100,        32'd7,          32'd14,         33);
        run_op("remu",       1, MD_REMU,   4'd0,     32'd100,        32'd7,          32'd2,          33);
        run_op("divu_zero",  1, MD_DIVU,   4'd0,     32'd100,        32'd0,          32'hFFFF_FFFF,  1);
        run_op("remu_zero",  1, MD_REMU,   4'd0,     32'd100,        32'd0,          32'd100,        1);
        run_op("div_ovf",    1, MD_DIV,    4'd0,     32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
        run_op("rem_ovf",    1, MD_REM,    4'd0,     32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1);
        run_op("divu_min",   1, MD_DIVU,   4'd0,     32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          33);
        run_op("sub",        0, 3'd0,      ALU_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE,  1);
        run_op("slt",        0, 3'd0,      ALU_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          1);
        run_op("sltu",       0, 3'd0,      ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          1);
        run_op("sra",        0, 3'd0,      ALU_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000,  1);
        run_op("srl",        0, 3'd0,      ALU_SRL,  32'h8000_0000,  32'd36,         32'h0800_0000,  1);
        run_op("eq",         0, 3'd0,      ALU_EQ,   32'd7,          32'd7,          32'd1,          1);
        run_op("xor_zero",   0, 3'd0,      ALU_XOR,  32'hA5A5_A5A5,  32'hA5A5_A5A5,  32'd0,          1);
        run_op("unknown",    0, 3'd0,      4'hF,     32'd9,          32'd9,          32'd0,          1);
        run_op("md_ignores_ctl", 1, MD_MUL, ALU_SUB, 32'd6,          32'd7,          32'd42,         33);

        // Stalled consumer: result held, new request ignored.
        out_ready = 1'b0;
        drive_op(0, 3'd0, ALU_OR, 32'hF0, 32'h0F);
        e.tag = "stall";
        e.res = 32'hFF;
        e.lat = 1;
        sb_q.push_back(e);
        collect(5);

        // Reset in the middle of a divide discards it.
        drive_op(1, MD_DIVU, 4'd0, 32'd1000, 32'd3);
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("abort.busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.busy", {63'd0, busy}, 64'd0);
        check("abort.in_ready", {63'd0, in_ready}, 64'd1);
        check("abort.out_valid", {63'd0, out_valid}, 64'd0);
        check("abort.result", {32'd0, alu_result}, 64'd0);
        check("abort.zero", {63'd0, zero}, 64'd1);
        run_op("sll_after_rst", 0, 3'd0, ALU_SLL, 32'd1, 32'd33, 32'd2, 1);

        // Random mix checked against the reference model.
        for (int i = 0; i < 24; i++) begin
            bit          md;
            logic [2:0]  op;
            logic [3:0]  ctl;
            logic [31:0] a, b;
            md  = 1'($urandom);
            op  = 3'($urandom);
            ctl = 4'($urandom_range(0, 11));
            a   = $urandom;
            b   = (i % 6 == 5) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            run_op($sformatf("rand%0d", i), md, op, ctl, a, b,
                   model(md, op, ctl, a, b), model_lat(md, op, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
